// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register byte offsets,
// CTRL field positions and the packed CTRL register layout.
package mmio_pkg;

    localparam logic [4:0] MTIME_LO_OFS = 5'h00;
    localparam logic [4:0] MTIME_HI_OFS = 5'h04;
    localparam logic [4:0] CMP_LO_OFS   = 5'h08;
    localparam logic [4:0] CMP_HI_OFS   = 5'h0C;
    localparam logic [4:0] CTRL_OFS     = 5'h10;
    localparam logic [4:0] STATUS_OFS   = 5'h14;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IE_BIT  = 1;
    localparam int CTRL_DIV_LSB = 8;
    localparam int STATUS_PEND_BIT = 0;

    typedef struct packed {
        logic [7:0] div;
        logic       ie;
        logic       en;
    } ctrl_t;

    // Software view of CTRL; unimplemented bits read as zero.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]         = c.en;
        w[CTRL_IE_BIT]         = c.ie;
        w[CTRL_DIV_LSB +: 8]   = c.div;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Data-memory bus as seen by the timer: the CPU drives the request side,
// the timer answers with combinational read data, window hit and its IRQ.
interface mmio_timer_if;
    logic        WE;
    logic        RE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Hit;
    logic        Irq;

    modport master (output WE, RE, A, WD, input RD, Hit, Irq);
    modport slave  (input WE, RE, A, WD, output RD, Hit, Irq);
endinterface

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler for the timer: counts 0..div while enabled and pulses tick on
// the cycle the count equals div. Disabling or restarting parks it at 0.
module tick_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] div,
    input  logic       restart,
    output logic       tick
);

    logic [7:0] r_count;
    logic       w_tick;

    // Tick is taken from the pre-edge count, so a restart in the same cycle
    // still lets a due tick through.
    assign w_tick = en && (r_count == div);
    assign tick   = w_tick;

    // Prescale counter: wrap after the terminal count, hold 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (restart || !en || w_tick) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit timer sitting beside dmem on the CPU data bus.
// Decodes a 32-byte window, provides free-running MTIME, a compare register,
// CTRL/STATUS and a registered level interrupt.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter logic [7:0]  DIV_RST   = 8'd0
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus
);

    logic        w_hit;
    logic [4:0]  w_ofs;
    logic        w_wr;
    logic        w_wr_mlo;
    logic        w_wr_mhi;
    logic        w_wr_clo;
    logic        w_wr_chi;
    logic        w_wr_ctrl;
    logic        w_clr;
    logic        w_tick;
    logic        w_match;
    logic        w_pend_next;
    logic        w_ie_next;
    logic [31:0] w_rd;
    ctrl_t       w_ctrl_wd;
    logic        w_unused_a;

    logic [63:0] r_mtime;
    logic [63:0] r_cmp;
    ctrl_t       r_ctrl;
    logic        r_pend;
    logic        r_irq;

    // Word access only; the byte lanes of the address are deliberately dropped.
    assign w_unused_a = &{1'b0, bus.A[1:0]};

    assign w_hit = (bus.A[31:5] == BASE_ADDR[31:5]);
    assign w_ofs = {bus.A[4:2], 2'b00};
    assign w_wr  = bus.WE && w_hit;

    assign w_wr_mlo  = w_wr && (w_ofs == MTIME_LO_OFS);
    assign w_wr_mhi  = w_wr && (w_ofs == MTIME_HI_OFS);
    assign w_wr_clo  = w_wr && (w_ofs == CMP_LO_OFS);
    assign w_wr_chi  = w_wr && (w_ofs == CMP_HI_OFS);
    assign w_wr_ctrl = w_wr && (w_ofs == CTRL_OFS);
    assign w_clr     = w_wr && (w_ofs == STATUS_OFS) && bus.WD[STATUS_PEND_BIT];

    assign w_ctrl_wd.div = bus.WD[CTRL_DIV_LSB +: 8];
    assign w_ctrl_wd.ie  = bus.WD[CTRL_IE_BIT];
    assign w_ctrl_wd.en  = bus.WD[CTRL_EN_BIT];

    // Match uses registered values only, so a write lands one cycle before
    // it can influence PEND. Setting wins over a simultaneous clear.
    assign w_match     = (r_mtime >= r_cmp);
    assign w_pend_next = w_match || (r_pend && !w_clr);
    assign w_ie_next   = w_wr_ctrl ? w_ctrl_wd.ie : r_ctrl.ie;

    tick_gen u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (r_ctrl.en),
        .div     (r_ctrl.div),
        .restart (w_wr_ctrl),
        .tick    (w_tick)
    );

    // MTIME: a software write to either half suppresses that cycle's increment
    // and leaves the other half at its pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= 64'd0;
        end else if (w_wr_mlo) begin
            r_mtime[31:0] <= bus.WD;
        end else if (w_wr_mhi) begin
            r_mtime[63:32] <= bus.WD;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Compare register, written a half at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= '1;
        end else begin
            if (w_wr_clo) begin
                r_cmp[31:0] <= bus.WD;
            end
            if (w_wr_chi) begin
                r_cmp[63:32] <= bus.WD;
            end
        end
    end

    // Control register: enable, interrupt enable and prescale divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '{div: DIV_RST, ie: 1'b0, en: 1'b0};
        end else if (w_wr_ctrl) begin
            r_ctrl <= w_ctrl_wd;
        end
    end

    // Pending flag and interrupt line; Irq follows next-state values so it
    // rises together with PEND and drops on the clearing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_irq  <= w_pend_next && w_ie_next;
        end
    end

    // Zero-latency read mux; unselected or reserved addresses return zero.
    always_comb begin
        w_rd = 32'h0;
        if (bus.RE && w_hit) begin
            case (w_ofs)
                MTIME_LO_OFS: w_rd = r_mtime[31:0];
                MTIME_HI_OFS: w_rd = r_mtime[63:32];
                CMP_LO_OFS:   w_rd = r_cmp[31:0];
                CMP_HI_OFS:   w_rd = r_cmp[63:32];
                CTRL_OFS:     w_rd = ctrl_to_word(r_ctrl);
                STATUS_OFS:   w_rd = {31'h0, r_pend};
                default:      w_rd = 32'h0;
            endcase
        end
    end

    assign bus.RD  = w_rd;
    assign bus.Hit = w_hit;
    assign bus.Irq = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(BASE), .DIV_RST(8'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (architectural view only)
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_ie, m_pend, m_irq;
    logic [7:0]  m_div;
    int          m_ph;

    logic [31:0] last_rd;
    logic        last_hit, last_irq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_en    = 1'b0;
        m_ie    = 1'b0;
        m_div   = 8'd0;
        m_pend  = 1'b0;
        m_irq   = 1'b0;
        m_ph    = 0;
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic [31:0] a);
        if (!(re && in_win(a))) return 32'h0;
        case (a[4:2])
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_mtime[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {16'h0, m_div, 6'h0, m_ie, m_en};
            3'd5:    return {31'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the timer, in terms of the register-level rules.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic        tick, wr, match, clr;
        logic [63:0] nm, nc;
        tick  = m_en && (m_ph == int'(m_div));
        wr    = we && in_win(a);
        match = (m_mtime >= m_cmp);
        nm = m_mtime;
        nc = m_cmp;
        if (wr && a[4:2] == 3'd0)      nm = {m_mtime[63:32], wd};
        else if (wr && a[4:2] == 3'd1) nm = {wd, m_mtime[31:0]};
        else if (tick)                 nm = m_mtime + 64'd1;
        if (wr && a[4:2] == 3'd2) nc = {m_cmp[63:32], wd};
        if (wr && a[4:2] == 3'd3) nc = {wd, m_cmp[31:0]};
        clr = wr && (a[4:2] == 3'd5) && wd[0];
        m_pend = match || (m_pend && !clr);
        if (wr && a[4:2] == 3'd4) begin
            m_en  = wd[0];
            m_ie  = wd[1];
            m_div = wd[15:8];
            m_ph  = 0;
        end else if (!m_en || tick) begin
            m_ph = 0;
        end else begin
            m_ph = m_ph + 1;
        end
        m_mtime = nm;
        m_cmp   = nc;
        m_irq   = m_pend && m_ie;
    endtask

    // Drive one bus cycle starting just after a rising edge, check the
    // combinational outputs before the next edge, then advance the model.
    task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd_o);
        bus.WE = we;
        bus.RE = re;
        bus.A  = a;
        bus.WD = wd;
        #3;
        last_rd  = bus.RD;
        last_hit = bus.Hit;
        last_irq = bus.Irq;
        check_val("hit", last_hit, in_win(a));
        check_val("rd", last_rd, model_read(re, a));
        check_val("irq", last_irq, m_irq);
        rd_o = last_rd;
        @(posedge clk);
        model_step(we, a, wd);
        #1;
    endtask

    task automatic wr(input logic [4:0] ofs, input logic [31:0] wd);
        logic [31:0] d;
        cyc(1'b1, 1'($urandom_range(0, 1)), BASE + 32'(ofs), wd, d);
    endtask

    task automatic rd(input logic [4:0] ofs, output logic [31:0] v);
        cyc(1'b0, 1'b1, BASE + 32'(ofs), 32'($urandom), v);
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 32'h0, d);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        model_reset();
        bus.WE = 1'b0;
        bus.RE = 1'b1;
        bus.A  = BASE;
        #1;
        check_val("rst_irq", bus.Irq, 1'b0);
        check_val("rst_mtime_lo", bus.RD, 32'h0);
        bus.A = BASE + 32'h8;
        #1;
        check_val("rst_cmp_lo", bus.RD, 32'hFFFF_FFFF);
        bus.RE = 1'b0;
        #1;
        check_val("rst_rd_noread", bus.RD, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] v, v2;
    logic        seen;

    initial begin
        rst    = 1'b1;
        bus.WE = 1'b0;
        bus.RE = 1'b0;
        bus.A  = 32'h0;
        bus.WD = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        check_val("reset_irq", bus.Irq, 1'b0);
        rst = 1'b0;

        // Reset values
        rd(5'h00, v);  check_val("reset_mtime_lo", v, 32'h0);
        rd(5'h04, v);  check_val("reset_mtime_hi", v, 32'h0);
        rd(5'h08, v);  check_val("reset_cmp_lo", v, 32'hFFFF_FFFF);
        rd(5'h0C, v);  check_val("reset_cmp_hi", v, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, BASE + 32'h8, 32'h0, v);
        check_val("reset_rd_re0", v, 32'h0);

        // Prescaler DIV=3: one tick per four clocks
        wr(5'h10, 32'h0000_0301);
        idle(40);
        rd(5'h00, v);  check_val("div3_40clk", v, 32'd10);

        // DIV=0: every clock
        wr(5'h10, 32'h0000_0001);
        rd(5'h00, v);
        idle(5);
        rd(5'h00, v2); check_val("div0_rate", v2, v + 32'd6);

        // Carry LO->HI
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h0000_0001);
        idle(1);
        rd(5'h04, v);  check_val("carry_hi", v, 32'h1);
        rd(5'h00, v);  check_val("carry_lo", v, 32'h1);

        // 64-bit wrap
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h10, 32'h0000_0001);
        idle(1);
        rd(5'h00, v);  check_val("wrap_lo", v, 32'h0);
        rd(5'h04, v);  check_val("wrap_hi", v, 32'h0);

        // Compare and interrupt
        wr(5'h10, 32'h0);
        wr(5'h0C, 32'hFFFF_FFFF);
        wr(5'h08, 32'h20);
        wr(5'h04, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h14, 32'h1);
        rd(5'h14, v);  check_val("cmp_pend_clear", v, 32'h0);
        wr(5'h10, 32'h0000_0003);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            rd(5'h00, v);
            if (last_irq) seen = 1'b1;
        end
        check_val("cmp_irq_seen", seen, 1'b1);
        if (seen) check_val("cmp_irq_mtime", v, 32'h21);
        wr(5'h14, 32'h1);
        rd(5'h14, v);  check_val("w1c_match_holds", v, 32'h1);

        // Clear by moving compare away, then IE=0 masks a pending flag
        wr(5'h0C, 32'h1);
        wr(5'h14, 32'h1);
        rd(5'h14, v);
        check_val("clr_pend", v, 32'h0);
        check_val("clr_irq", last_irq, 1'b0);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h0000_0001);
        rd(5'h14, v);
        check_val("ie0_pend", v, 32'h1);
        check_val("ie0_irq", last_irq, 1'b0);

        // Decode
        cyc(1'b1, 1'b1, BASE + 32'h40, 32'hDEAD_BEEF, v);
        check_val("dec_hi_hit", last_hit, 1'b0);
        check_val("dec_hi_rd", v, 32'h0);
        cyc(1'b1, 1'b1, BASE - 32'h4, 32'hDEAD_BEEF, v);
        check_val("dec_lo_hit", last_hit, 1'b0);
        check_val("dec_lo_rd", v, 32'h0);
        rd(5'h18, v);  check_val("reserved_rd", v, 32'h0);
        wr(5'h00, 32'h1234_5678);
        rd(5'h00, v);  check_val("wd_wins_tick", v, 32'h1234_5678);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int          op;
            logic [31:0] a, wd;
            logic [63:0] t;
            logic [2:0]  w;
            op = $urandom_range(0, 99);
            w  = 3'($urandom_range(0, 7));
            a  = BASE + {27'h0, w, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: a = BASE + 32'h40;
                    1: a = BASE - 32'h4;
                    2: a = BASE + 32'h20 + {27'h0, w, 2'b00};
                    default: a = $urandom;
                endcase
            end
            wd = $urandom;
            t  = m_mtime + 64'($urandom_range(0, 30));
            case (w)
                3'd0, 3'd1: if ($urandom_range(0, 1) == 0) wd = (w == 3'd0) ? t[31:0] : t[63:32];
                3'd2, 3'd3: if ($urandom_range(0, 2) != 0) wd = (w == 3'd2) ? t[31:0] : t[63:32];
                3'd4: begin
                    wd[15:8] = 8'($urandom_range(0, 3));
                    wd[0]    = ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            if (op < 30)      cyc(1'b0, 1'($urandom_range(0, 1)), a, wd, v);
            else if (op < 65) cyc(1'b0, 1'b1, a, wd, v);
            else              cyc(1'b1, 1'($urandom_range(0, 1)), a, wd, v);
        end

        // Asynchronous reset in the middle of counting with Irq asserted
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'h0);
        wr(5'h10, 32'h0000_0303);
        idle(7);
        check_val("pre_rst_irq", last_irq, 1'b1);
        mid_reset();
        rd(5'h00, v);  check_val("post_rst_mtime", v, 32'h0);
        rd(5'h0C, v);  check_val("post_rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(5'h10, v);  check_val("post_rst_ctrl", v, 32'h0);
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
